proc_run_ctrl: RTL and testbench

Run controller for the `processor_only` core. It holds the core in reset while a program is streamed word-by-word into instruction memory, then releases the core. While the core runs, it counts cycles and watches `a7` for the exit code. It stops the core on exit, timeout or abort, and latches `gp` as the run result for the logic analyzer.

---
 rtl/run_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 33 +++
 rtl/proc_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_proc_run_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the processor run controller: state encoding and constants.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } run_state_e;

  localparam int unsigned DEFAULT_EXIT_CODE = 93;
  localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// 32-bit up-counter with synchronous clear (dominant) and enable, sticking at CYC_MAX.
module sat_counter
  import run_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CYC_MAX)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: streams a program into IMEM while the core is held in reset, then
// runs the core until exit code, cycle budget or abort, latching gp as the result.
module proc_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          IMEM_DEPTH = 512,
  parameter int          ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int unsigned EXIT_CODE  = DEFAULT_EXIT_CODE
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic [31:0]       max_cycles_i,
  input  logic              ld_valid_i,
  input  logic [WIDTH-1:0]  ld_data_i,
  output logic              ld_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [WIDTH-1:0]  imem_wdata_o,
  output logic              core_rst_o,
  input  logic [WIDTH-1:0]  a7_i,
  input  logic [WIDTH-1:0]  gp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [31:0]       cycles_o
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [WIDTH-1:0] EXIT_W  = WIDTH'(EXIT_CODE);

  run_state_e        state_d, state_q;
  logic [ADDR_W:0]   ptr_d, ptr_q;
  logic [ADDR_W:0]   len_d, len_q;
  logic [31:0]       budget_d, budget_q;
  logic              done_d, done_q;
  logic              timeout_d, timeout_q;
  logic [WIDTH-1:0]  result_d, result_q;
  logic              imem_we_d, imem_we_q;
  logic [ADDR_W-1:0] imem_addr_d, imem_addr_q;
  logic [WIDTH-1:0]  imem_wdata_d, imem_wdata_q;
  logic              cyc_clr, cyc_en;
  logic              ld_hs;
  logic [ADDR_W:0]   ptr_inc;
  logic [ADDR_W:0]   len_clamped;
  logic              budget_hit;

  assign ld_ready_o  = (state_q == ST_LOAD) && !abort_i;
  assign ld_hs       = ld_ready_o && ld_valid_i;
  assign ptr_inc     = ptr_q + PTR_ONE;
  assign len_clamped = (load_len_i > DEPTH_L) ? DEPTH_L : load_len_i;
  // 33-bit compare so a budget of 0xFFFFFFFF never wraps against the counter.
  assign budget_hit  = (budget_q != 32'd0) &&
                       (({1'b0, cycles_o} + 33'd1) == {1'b0, budget_q});

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    budget_d     = budget_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    result_d     = result_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cyc_clr      = 1'b0;
    cyc_en       = 1'b0;
    if (abort_i) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      result_d  = '0;
      cyc_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
            result_d  = '0;
            cyc_clr   = 1'b1;
            len_d     = len_clamped;
            budget_d  = max_cycles_i;
            ptr_d     = '0;
            state_d   = (len_clamped != '0) ? ST_LOAD : ST_ARM;
          end
        end
        ST_LOAD: begin
          if (ld_hs) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ptr_q[ADDR_W-1:0];
            imem_wdata_d = ld_data_i;
            ptr_d        = ptr_inc;
            if (ptr_inc == len_q) begin
              state_d = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          cyc_en = 1'b1;
          // Exit code takes priority over an expiring budget in the same cycle.
          if (a7_i == EXIT_W) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = gp_i;
          end else if (budget_hit) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
            result_d  = gp_i;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      budget_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      result_q     <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      budget_q     <= budget_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      result_q     <= result_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  sat_counter u_cycles (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clr_i   (cyc_clr),
    .en_i    (cyc_en),
    .count_o (cycles_o)
  );

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign core_rst_o   = (state_q != ST_RUN);
  assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_ARM) || (state_q == ST_RUN);
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign result_o     = result_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: a per-cycle vector table for load+run, plus
// directed sequences for budget, abort, length clamp and asynchronous reset.
module tb_proc_run_ctrl;

  typedef struct packed {
    logic        start;
    logic [9:0]  len;
    logic [31:0] maxc;
    logic        valid;
    logic [31:0] data;
    logic [31:0] a7;
    logic [31:0] gp;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_crst;
    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_cycles;
    logic [31:0] exp_result;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [9:0]  load_len_i;
  logic [31:0] max_cycles_i;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic        imem_we_o;
  logic [8:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        core_rst_o;
  logic [31:0] a7_i;
  logic [31:0] gp_i;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic [31:0] result_o;
  logic [31:0] cycles_o;

  int checks   = 0;
  int failures = 0;

  int          wr_count = 0;
  logic [8:0]  wr_addr_log [0:1023];
  logic [31:0] wr_data_log [0:1023];

  vec_t vecs [0:16];

  always #5 clk = ~clk;

  proc_run_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .load_len_i   (load_len_i),
    .max_cycles_i (max_cycles_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_o   (core_rst_o),
    .a7_i         (a7_i),
    .gp_i         (gp_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .result_o     (result_o),
    .cycles_o     (cycles_o)
  );

  // IMEM write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we_o) begin
      wr_addr_log[wr_count[9:0]] = imem_addr_o;
      wr_data_log[wr_count[9:0]] = imem_wdata_o;
      wr_count = wr_count + 1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic start, input logic [9:0] len, input logic [31:0] maxc,
                              input logic valid, input logic [31:0] data, input logic [31:0] a7,
                              input logic [31:0] gp, input logic we, input logic [8:0] addr,
                              input logic [31:0] wdata, input logic crst, input logic busy,
                              input logic done, input logic [31:0] cyc, input logic [31:0] res);
    vec_t v;
    v.start = start; v.len = len; v.maxc = maxc; v.valid = valid; v.data = data;
    v.a7 = a7; v.gp = gp; v.exp_we = we; v.exp_addr = addr; v.exp_wdata = wdata;
    v.exp_crst = crst; v.exp_busy = busy; v.exp_done = done; v.exp_cycles = cyc;
    v.exp_result = res;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start_i      = v.start;
    abort_i      = 1'b0;
    load_len_i   = v.len;
    max_cycles_i = v.maxc;
    ld_valid_i   = v.valid;
    ld_data_i    = v.data;
    a7_i         = v.a7;
    gp_i         = v.gp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a resident-program rerun with budget 5; optionally exit on the 5th RUN cycle.
  task automatic runBudgetCase(input logic exit_on_5, input logic [31:0] gp_val);
    int base;
    base         = wr_count;
    start_i      = 1'b1;
    load_len_i   = 10'd0;
    max_cycles_i = 32'd5;
    a7_i         = 32'd0;
    gp_i         = gp_val;
    tick();
    start_i = 1'b0;
    checkOutput("rerun_arm_busy", 32'(busy_o), 32'd1);
    checkOutput("rerun_arm_core_rst", 32'(core_rst_o), 32'd1);
    checkOutput("rerun_clear_done", 32'(done_o), 32'd0);
    checkOutput("rerun_clear_result", result_o, 32'd0);
    checkOutput("rerun_clear_cycles", cycles_o, 32'd0);
    tick();
    checkOutput("rerun_run_core_rst", 32'(core_rst_o), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      if (exit_on_5 && k == 5) a7_i = 32'd93;
      tick();
      if (k < 5) begin
        checkOutput("budget_still_busy", 32'(busy_o), 32'd1);
        checkOutput("budget_cycles", cycles_o, 32'(k));
      end
    end
    a7_i = 32'd0;
    checkOutput("budget_end_busy", 32'(busy_o), 32'd0);
    checkOutput("budget_end_core_rst", 32'(core_rst_o), 32'd1);
    checkOutput("budget_end_done", 32'(done_o), 32'(exit_on_5));
    checkOutput("budget_end_timeout", 32'(timeout_o), 32'(!exit_on_5));
    checkOutput("budget_end_cycles", cycles_o, 32'd5);
    checkOutput("budget_end_result", result_o, gp_val);
    checkOutput("rerun_no_writes", 32'(wr_count - base), 32'd0);
  endtask

  initial begin
    int base;
    int hs;
    logic aborted;

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; load_len_i = '0; max_cycles_i = '0;
    ld_valid_i = 1'b0; ld_data_i = '0; a7_i = '0; gp_i = '0;

    vecs[0]  = mk(1, 10'd4, 0, 0, 32'h00, 0, 0,       0, 9'd0, 32'h00, 1, 1, 0, 0, 0);
    vecs[1]  = mk(0, 10'd0, 0, 1, 32'h11, 0, 0,       1, 9'd0, 32'h11, 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 10'd0, 0, 1, 32'h22, 0, 0,       1, 9'd1, 32'h22, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 10'd0, 0, 1, 32'h33, 0, 0,       1, 9'd2, 32'h33, 1, 1, 0, 0, 0);
    vecs[4]  = mk(0, 10'd0, 0, 1, 32'h44, 0, 0,       1, 9'd3, 32'h44, 1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 10'd0, 0, 0, 32'h00, 0, 0,       0, 9'd3, 32'h44, 0, 1, 0, 0, 0);
    for (int i = 6; i <= 14; i++) begin
      vecs[i] = mk(0, 10'd0, 0, 0, 32'h00, 0, 32'h1234, 0, 9'd3, 32'h44, 0, 1, 0, 32'(i - 5), 0);
    end
    vecs[15] = mk(0, 10'd0, 0, 0, 32'h00, 93, 32'hCAFE, 0, 9'd3, 32'h44, 1, 0, 1, 32'd10, 32'hCAFE);
    vecs[16] = mk(0, 10'd0, 0, 0, 32'h00, 0, 32'h0,    0, 9'd3, 32'h44, 1, 0, 1, 32'd10, 32'hCAFE);

    #12;
    checkOutput("reset_core_rst", 32'(core_rst_o), 32'd1);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_ld_ready", 32'(ld_ready_o), 32'd0);
    checkOutput("reset_we", 32'(imem_we_o), 32'd0);
    checkOutput("reset_addr", 32'(imem_addr_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_timeout", 32'(timeout_o), 32'd0);
    checkOutput("reset_result", result_o, 32'd0);
    checkOutput("reset_cycles", cycles_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i <= 16; i++) begin
      applyStimulus(vecs[i]);
      if (i >= 1 && i <= 4) checkOutput("tbl_ld_ready", 32'(ld_ready_o), 32'd1);
      tick();
      checkOutput("tbl_we", 32'(imem_we_o), 32'(vecs[i].exp_we));
      checkOutput("tbl_addr", 32'(imem_addr_o), 32'(vecs[i].exp_addr));
      checkOutput("tbl_wdata", imem_wdata_o, vecs[i].exp_wdata);
      checkOutput("tbl_core_rst", 32'(core_rst_o), 32'(vecs[i].exp_crst));
      checkOutput("tbl_busy", 32'(busy_o), 32'(vecs[i].exp_busy));
      checkOutput("tbl_done", 32'(done_o), 32'(vecs[i].exp_done));
      checkOutput("tbl_timeout", 32'(timeout_o), 32'd0);
      checkOutput("tbl_cycles", cycles_o, vecs[i].exp_cycles);
      checkOutput("tbl_result", result_o, vecs[i].exp_result);
    end

    runBudgetCase(1'b0, 32'h55);
    runBudgetCase(1'b1, 32'h77);

    // Abort from DONE clears the latched run outcome.
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checkOutput("abort_done_flag", 32'(done_o), 32'd0);
    checkOutput("abort_done_result", result_o, 32'd0);
    checkOutput("abort_done_cycles", cycles_o, 32'd0);
    checkOutput("abort_done_busy", 32'(busy_o), 32'd0);

    // Abort on the cycle of the 3rd handshake with a randomly toggling valid.
    base = wr_count;
    hs = 0;
    aborted = 1'b0;
    start_i = 1'b1; load_len_i = 10'd8; max_cycles_i = 32'd0;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 200 && !aborted; c++) begin
      ld_valid_i = 1'($urandom_range(0, 1));
      ld_data_i  = 32'hA0 + 32'(c);
      if (ld_valid_i && hs == 2) abort_i = 1'b1;
      #1;
      checkOutput("abort_ld_ready", 32'(ld_ready_o), 32'(!abort_i));
      tick();
      if (abort_i) aborted = 1'b1;
      else if (ld_valid_i) hs = hs + 1;
    end
    abort_i = 1'b0;
    ld_valid_i = 1'b0;
    checkOutput("abort_reached", 32'(aborted), 32'd1);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_core_rst", 32'(core_rst_o), 32'd1);
    checkOutput("abort_done", 32'(done_o), 32'd0);
    checkOutput("abort_timeout", 32'(timeout_o), 32'd0);
    checkOutput("abort_we_suppressed", 32'(imem_we_o), 32'd0);
    tick();
    checkOutput("abort_write_count", 32'(wr_count - base), 32'd2);
    checkOutput("abort_write0_addr", 32'(wr_addr_log[base[9:0]]), 32'd0);
    checkOutput("abort_write1_addr", 32'(wr_addr_log[10'(base + 1)]), 32'd1);

    // Oversized length is clamped to the IMEM depth.
    base = wr_count;
    start_i = 1'b1; load_len_i = 10'd600; max_cycles_i = 32'd0; a7_i = 32'd93; gp_i = 32'hBEEF;
    tick();
    start_i = 1'b0;
    ld_valid_i = 1'b1;
    for (int i = 0; i < 700; i++) begin
      ld_data_i = 32'(i);
      tick();
      if (!busy_o) break;
    end
    ld_valid_i = 1'b0;
    a7_i = 32'd0;
    tick();
    checkOutput("clamp_finished", 32'(busy_o), 32'd0);
    checkOutput("clamp_write_count", 32'(wr_count - base), 32'd512);
    checkOutput("clamp_last_addr", 32'(wr_addr_log[10'(base + 511)]), 32'd511);
    checkOutput("clamp_last_data", wr_data_log[10'(base + 511)], 32'd511);
    checkOutput("clamp_done", 32'(done_o), 32'd1);
    checkOutput("clamp_cycles", cycles_o, 32'd1);
    checkOutput("clamp_result", result_o, 32'hBEEF);

    // Asynchronous reset mid-RUN acts before the next clock edge.
    start_i = 1'b1; load_len_i = 10'd0; max_cycles_i = 32'd0; a7_i = 32'd0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_reset_core_rst", 32'(core_rst_o), 32'd0);
    checkOutput("pre_reset_cycles", cycles_o, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_core_rst", 32'(core_rst_o), 32'd1);
    checkOutput("async_reset_busy", 32'(busy_o), 32'd0);
    checkOutput("async_reset_cycles", cycles_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
